// File: rtl/pwm_pkg.sv
// Shared constants for the PWM register bank: register map, CTRL/STATUS
// bit positions and prescaler divide encodings.
package pwm_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_INV    = 1;
  localparam int CTRL_PSC_LO = 2;
  localparam int CTRL_PSC_HI = 3;
  localparam int CTRL_W      = 4;

  localparam int STAT_PEND = 0;
  localparam int STAT_DONE = 1;

  localparam logic [1:0] PSC_DIV1  = 2'b00;
  localparam logic [1:0] PSC_DIV4  = 2'b01;
  localparam logic [1:0] PSC_DIV16 = 2'b10;
  localparam logic [1:0] PSC_DIV64 = 2'b11;

  localparam int PSC_CNT_W = 6;

  // Terminal count (divide ratio minus one) for each prescaler setting.
  function automatic logic [PSC_CNT_W-1:0] psc_max(input logic [1:0] psc);
    case (psc)
      PSC_DIV1:  return 6'd0;
      PSC_DIV4:  return 6'd3;
      PSC_DIV16: return 6'd15;
      default:   return 6'd63;
    endcase
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: emits a single-cycle tick every 1/4/16/64 clk cycles
// while enabled; held at zero when disabled or restarted.
module pwm_prescaler
  import pwm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] psc,
  input  logic       restart,
  output logic       tick
);

  logic [PSC_CNT_W-1:0] cnt;

  assign tick = en && (cnt == psc_max(psc));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_reg_ctrl.sv
// PWM register bank and sequencer: edge-committed SPI writes into shadow
// registers, period counter, and shadow-to-active transfer at each wrap.
module pwm_reg_ctrl
  import pwm_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] RST_PERIOD = DATA_W'(8'hFF),
  parameter logic [DATA_W-1:0] RST_DUTY   = DATA_W'(8'h80)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        addr_i,
  input  logic [DATA_W-1:0] data_wr_i,
  input  logic              wr_en_i,
  output logic [DATA_W-1:0] data_rd_o,
  output logic              pwm_o,
  output logic              period_tick_o
);

  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] sh_period, sh_duty, act_period, act_duty, cnt;
  logic              pend, done, wr_en_q;
  logic              en, inv, tick, wrap, commit;
  logic              wr_ctrl, wr_period, wr_duty, wr_status;
  logic [1:0]        psc;

  assign en  = ctrl[CTRL_EN];
  assign inv = ctrl[CTRL_INV];
  assign psc = ctrl[CTRL_PSC_HI:CTRL_PSC_LO];

  // A held strobe commits only on its first cycle.
  assign commit    = wr_en_i && !wr_en_q;
  assign wr_ctrl   = commit && (addr_i == ADDR_CTRL);
  assign wr_period = commit && (addr_i == ADDR_PERIOD);
  assign wr_duty   = commit && (addr_i == ADDR_DUTY);
  assign wr_status = commit && (addr_i == ADDR_STATUS);

  pwm_prescaler u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .psc     (psc),
    .restart (wr_ctrl),
    .tick    (tick)
  );

  assign wrap  = tick && (cnt == act_period);
  assign pwm_o = (en && (cnt < act_duty)) ^ inv;

  always_comb begin
    data_rd_o = '0;
    case (addr_i)
      ADDR_CTRL:   data_rd_o[CTRL_W-1:0] = ctrl;
      ADDR_PERIOD: data_rd_o = sh_period;
      ADDR_DUTY:   data_rd_o = sh_duty;
      default: begin
        data_rd_o[STAT_PEND] = pend;
        data_rd_o[STAT_DONE] = done;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl          <= '0;
      sh_period     <= RST_PERIOD;
      sh_duty       <= RST_DUTY;
      act_period    <= RST_PERIOD;
      act_duty      <= RST_DUTY;
      cnt           <= '0;
      pend          <= 1'b0;
      done          <= 1'b0;
      wr_en_q       <= 1'b0;
      period_tick_o <= 1'b0;
    end else begin
      wr_en_q       <= wr_en_i;
      period_tick_o <= wrap;
      if (wr_ctrl)   ctrl      <= data_wr_i[CTRL_W-1:0];
      if (wr_period) sh_period <= data_wr_i;
      if (wr_duty)   sh_duty   <= data_wr_i;

      // The active set sees the pre-write shadow on a coincident wrap.
      if (!en) begin
        cnt        <= '0;
        act_period <= sh_period;
        act_duty   <= sh_duty;
        pend       <= 1'b0;
      end else begin
        if (tick) cnt <= wrap ? '0 : cnt + 1'b1;
        if (wrap) begin
          act_period <= sh_period;
          act_duty   <= sh_duty;
        end
        if (wr_period || wr_duty) pend <= 1'b1;
        else if (wrap)            pend <= 1'b0;
      end

      if (wrap)                                 done <= 1'b1;
      else if (wr_status && data_wr_i[STAT_DONE]) done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_reg_ctrl.sv
// Self-checking bench for pwm_reg_ctrl: directed scenarios then random
// register traffic, compared every cycle against a behavioural model.
module tb_pwm_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] addr_i;
  logic [7:0] data_wr_i;
  logic       wr_en_i;
  logic [7:0] data_rd_o;
  logic       pwm_o;
  logic       period_tick_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_ctrl, m_sp, m_sd, m_ap, m_ad, m_cnt, m_ps;
  bit m_pend, m_done, m_wq, m_tick;

  always #5 clk = ~clk;

  pwm_reg_ctrl #(.DATA_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .addr_i        (addr_i),
    .data_wr_i     (data_wr_i),
    .wr_en_i       (wr_en_i),
    .data_rd_o     (data_rd_o),
    .pwm_o         (pwm_o),
    .period_tick_o (period_tick_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ctrl = 0; m_sp = 8'hFF; m_sd = 8'h80; m_ap = 8'hFF; m_ad = 8'h80;
    m_cnt = 0; m_ps = 0; m_pend = 0; m_done = 0; m_wq = 0; m_tick = 0;
  endtask

  function automatic int m_div();
    return 1 << (2 * ((m_ctrl >> 2) & 3));
  endfunction

  function automatic bit m_wrap();
    return (m_ctrl & 1) != 0 && ((m_ps + 1) % m_div()) == 0 && m_cnt == m_ap;
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return 8'(m_ctrl & 15);
      2'd1:    return 8'(m_sp);
      2'd2:    return 8'(m_sd);
      default: return {6'd0, m_done, m_pend};
    endcase
  endfunction

  function automatic bit m_pwm();
    return (((m_ctrl & 1) != 0) && (m_cnt < m_ad)) ^ ((m_ctrl & 2) != 0);
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, "_rd"}, data_rd_o, m_read(addr_i));
    chk({tag, "_pwm"}, pwm_o, m_pwm());
    chk({tag, "_tick"}, period_tick_o, m_tick);
  endtask

  // One clk edge: advance the model from the current inputs, then compare.
  task automatic cycle();
    bit commit, en, tick, wrap;
    int n_ctrl, n_sp, n_sd, n_ap, n_ad, n_cnt, n_ps;
    bit n_pend, n_done;
    commit = wr_en_i && !m_wq;
    en     = (m_ctrl & 1) != 0;
    tick   = en && ((m_ps + 1) % m_div()) == 0;
    wrap   = m_wrap();
    n_ctrl = (commit && addr_i == 2'd0) ? int'(data_wr_i) & 15 : m_ctrl;
    n_sp   = (commit && addr_i == 2'd1) ? int'(data_wr_i) : m_sp;
    n_sd   = (commit && addr_i == 2'd2) ? int'(data_wr_i) : m_sd;
    n_ap = m_ap; n_ad = m_ad; n_pend = m_pend; n_done = m_done;
    if (!en) begin
      n_ps = 0; n_cnt = 0; n_ap = m_sp; n_ad = m_sd; n_pend = 0;
    end else begin
      n_ps  = (commit && addr_i == 2'd0) ? 0 : (m_ps + 1) % m_div();
      n_cnt = !tick ? m_cnt : (wrap ? 0 : m_cnt + 1);
      if (wrap) begin n_ap = m_sp; n_ad = m_sd; n_pend = 0; end
      if (commit && (addr_i == 2'd1 || addr_i == 2'd2)) n_pend = 1;
    end
    if (wrap) n_done = 1;
    else if (commit && addr_i == 2'd3 && data_wr_i[1]) n_done = 0;
    @(posedge clk);
    m_ctrl = n_ctrl; m_sp = n_sp; m_sd = n_sd; m_ap = n_ap; m_ad = n_ad;
    m_cnt = n_cnt; m_ps = n_ps; m_pend = n_pend; m_done = n_done;
    m_tick = wrap; m_wq = wr_en_i;
    #1;
    check_outs("cyc");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input int hold);
    addr_i = a; data_wr_i = d; wr_en_i = 1'b1;
    for (int i = 0; i < hold; i++) cycle();
    wr_en_i = 1'b0;
    cycle();
  endtask

  // Advance until the next clk edge is a wrap edge.
  task automatic wait_wrap();
    for (int i = 0; i < 3000; i++) begin
      if (m_wrap()) break;
      cycle();
    end
    chk("wrap_wait", m_wrap(), 1'b1);
  endtask

  task automatic read_stat(input string tag, input logic [7:0] exp);
    addr_i = 2'd3; #1;
    chk(tag, data_rd_o, exp);
    chk({tag, "_model"}, data_rd_o, m_read(2'd3));
  endtask

  initial begin
    logic [7:0] rst_vals [4];
    int hi, tk;
    rst_vals[0] = 8'h00; rst_vals[1] = 8'hFF; rst_vals[2] = 8'h80; rst_vals[3] = 8'h00;
    rst_n = 1'b0; addr_i = 2'd0; data_wr_i = 8'd0; wr_en_i = 1'b0;
    m_reset();
    #12;
    for (int a = 0; a < 4; a++) begin
      addr_i = 2'(a); #1;
      chk("rst_rd", data_rd_o, rst_vals[a]);
    end
    chk("rst_pwm", pwm_o, 1'b0);
    chk("rst_tick", period_tick_o, 1'b0);
    rst_n = 1'b1;
    run(2);

    // Basic run: PERIOD=3 DUTY=2 /1, held strobes
    wr(2'd1, 8'd3, 5);
    wr(2'd2, 8'd2, 5);
    wr(2'd0, 8'h01, 5);
    wait_wrap();
    cycle();
    hi = 0; tk = 0;
    for (int i = 0; i < 8; i++) begin
      hi += int'(pwm_o); tk += int'(period_tick_o);
      chk("pattern", pwm_o, (i % 4) < 2);
      cycle();
    end
    chk("pattern_hi", hi, 4);
    chk("pattern_tick", tk, 2);
    read_stat("done_set", 8'h02);

    // PSC=/4, PERIOD=9 DUTY=5, then DUTY=8 mid-period
    wr(2'd0, 8'h05, 1);
    wr(2'd1, 8'd9, 1);
    wr(2'd2, 8'd5, 1);
    wait_wrap();
    run(12);
    wr(2'd2, 8'd8, 2);
    read_stat("pend_mid", 8'h03);
    wait_wrap();
    cycle();
    read_stat("pend_clr", 8'h02);
    run(40);

    // DUTY write landing exactly on a wrap edge
    wait_wrap();
    addr_i = 2'd2; data_wr_i = 8'd3; wr_en_i = 1'b1;
    cycle();
    wr_en_i = 1'b0;
    read_stat("pend_wrapedge", 8'h03);
    wait_wrap();
    cycle();
    read_stat("pend_next", 8'h02);

    // Edge values: DUTY=0, DUTY>PERIOD, INV, PERIOD=0
    wr(2'd0, 8'h00, 1);
    wr(2'd1, 8'h10, 1);
    wr(2'd2, 8'h00, 1);
    wr(2'd0, 8'h01, 1);
    hi = 0;
    for (int i = 0; i < 40; i++) begin hi += int'(pwm_o); cycle(); end
    chk("duty0_low", hi, 0);
    wr(2'd0, 8'h03, 1);
    hi = 0;
    for (int i = 0; i < 40; i++) begin hi += int'(pwm_o); cycle(); end
    chk("duty0_inv", hi, 40);
    wr(2'd0, 8'h00, 1);
    wr(2'd2, 8'hFF, 1);
    wr(2'd0, 8'h01, 1);
    hi = 0;
    for (int i = 0; i < 40; i++) begin hi += int'(pwm_o); cycle(); end
    chk("dutyff_high", hi, 40);
    wr(2'd0, 8'h03, 1);
    hi = 0;
    for (int i = 0; i < 40; i++) begin hi += int'(pwm_o); cycle(); end
    chk("dutyff_inv", hi, 0);
    wr(2'd0, 8'h00, 1);
    wr(2'd1, 8'h00, 1);
    wr(2'd0, 8'h01, 1);
    tk = 0;
    for (int i = 0; i < 20; i++) begin tk += int'(period_tick_o); cycle(); end
    chk("period0_ticks", tk, 20);

    // W1C on a wrap edge (set wins), then mid-period (clears)
    wr(2'd1, 8'd3, 1);
    wait_wrap();
    addr_i = 2'd3; data_wr_i = 8'h02; wr_en_i = 1'b1;
    cycle();
    wr_en_i = 1'b0;
    read_stat("w1c_wrap", 8'h02);
    cycle();
    for (int i = 0; i < 20 && !(m_cnt == 0 && !m_wrap()); i++) cycle();
    wr(2'd3, 8'h02, 1);
    read_stat("w1c_mid", 8'h00);

    // Asynchronous reset mid-period
    wr(2'd1, 8'd9, 1);
    wait_wrap();
    run(5);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    for (int a = 0; a < 4; a++) begin
      addr_i = 2'(a); #1;
      chk("arst_rd", data_rd_o, rst_vals[a]);
    end
    chk("arst_pwm", pwm_o, 1'b0);
    chk("arst_tick", period_tick_o, 1'b0);
    rst_n = 1'b1;
    run(2);

    // Random register traffic
    for (int n = 0; n < 200; n++) begin
      logic [1:0] a;
      logic [7:0] d;
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      if (a == 2'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      if (a == 2'd1 && $urandom_range(0, 1) != 0) d = d & 8'h1F;
      wr(a, d, $urandom_range(1, 4));
      run($urandom_range(0, 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
